wam_judge: RTL and testbench

//  Hammer-side judge of the whac-a-mole datapath. Debounces the 8 raw hole buttons and

---
 rtl/wam_judge.sv | 142 ++++++++++++++
 tb/tb_wam_judge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wam_judge.sv
// wam_judge -- hammer-side judge of the whac-a-mole datapath.
//
// Synchronises and debounces the eight raw hole buttons.  Each clean press
// (a 0->1 edge of the debounced level) is queued in a pending bit.  One
// pending bit is serviced per clock, lowest index first.  A service scores a
// hit when the mole is up and not already hit, is ignored when the mole is up
// but already hit, and counts a miss when the hole is empty.
//
// Ports
//   clk        system clock
//   clr        asynchronous active-high reset
//   sample_en  one-clk debounce sampling strobe
//   btn[7:0]   raw hole buttons, active-high, asynchronous
//   holes[7:0] mole present per hole, from wam_gen
//   hit[7:0]   per-hole hit request to wam_gen; held until holes[k] drops
//   score[7:0] BCD hit count {tens,ones}, saturates at 99
//   miss[7:0]  BCD miss count {tens,ones}, saturates at 99
//   cout0      one-clk level-up pulse every LVL_PTS hits
module wam_judge #(
    parameter int DB_CNT  = 16,   // 2..255 sample ticks to accept a level
    parameter int LVL_PTS = 10    // 1..255 hits per level-up pulse
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sample_en,
    input  logic [7:0] btn,
    input  logic [7:0] holes,
    output logic [7:0] hit,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic       cout0
);

    localparam logic [7:0] DB_MAX  = 8'(DB_CNT - 1);
    localparam logic [7:0] LVL_MAX = 8'(LVL_PTS - 1);

    logic [7:0] sync1, sync2;
    logic [7:0] stable, stable_q;
    logic [7:0] dbc [8];
    logic [7:0] pend;
    logic [7:0] lvl;

    logic [7:0] rise;
    logic [7:0] svc;       // one-hot of the serviced pend bit (0 if none)
    logic [2:0] svc_idx;
    logic       do_hit;
    logic       do_miss;

    // Saturating BCD increment: 99 holds.
    function automatic logic [7:0] bcd_inc(input logic [7:0] x);
        logic [7:0] r;
        if (x == 8'h99)
            r = x;
        else if (x[3:0] == 4'd9)
            r = {x[7:4] + 4'd1, 4'd0};
        else
            r = {x[7:4], x[3:0] + 4'd1};
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and per-bit debounce.  A bit flips once sync has
    // differed from stable on DB_CNT consecutive sample ticks; any tick
    // where they agree restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 8; i++)
                dbc[i] <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_q <= stable;
            if (sample_en) begin
                for (int i = 0; i < 8; i++) begin
                    if (sync2[i] == stable[i]) begin
                        dbc[i] <= '0;
                    end else if (dbc[i] == DB_MAX) begin
                        stable[i] <= sync2[i];
                        dbc[i]    <= '0;
                    end else begin
                        dbc[i] <= dbc[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign rise = stable & ~stable_q;

    // ------------------------------------------------------------------
    // Fixed-priority arbiter: lowest set pend bit wins.
    // ------------------------------------------------------------------
    always_comb begin
        svc_idx = '0;
        for (int i = 7; i >= 0; i--)
            if (pend[i])
                svc_idx = 3'(i);
    end

    assign svc     = pend & (~pend + 8'd1);
    assign do_hit  = (|pend) &  holes[svc_idx] & ~hit[svc_idx];
    assign do_miss = (|pend) & ~holes[svc_idx];

    // ------------------------------------------------------------------
    // Pending, hit handshake, counters.
    // A rise on the bit being serviced re-arms it, since the OR with rise
    // comes after the service clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend  <= '0;
            hit   <= '0;
            score <= '0;
            miss  <= '0;
            lvl   <= '0;
            cout0 <= 1'b0;
        end else begin
            pend  <= (pend & ~svc) | rise;
            // Hits drop the clock after wam_gen clears the hole; a new hit
            // is only ever set on a hole that is currently up.
            hit   <= (hit & holes) | (do_hit ? svc : 8'h00);
            cout0 <= 1'b0;
            if (do_hit) begin
                score <= bcd_inc(score);
                if (lvl == LVL_MAX) begin
                    lvl   <= '0;
                    cout0 <= 1'b1;
                end else begin
                    lvl <= lvl + 8'd1;
                end
            end
            if (do_miss)
                miss <= bcd_inc(miss);
        end
    end

endmodule

// File: tb/tb_wam_judge.sv
// Self-checking bench for wam_judge.  A transaction-level model tracks the
// expected score, miss, hit map and level pulses per clean press.
module tb_wam_judge;

    localparam int DB = 16;
    localparam int LP = 10;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sample_en = 1'b0;
    logic [7:0] btn = 8'h00;
    logic [7:0] holes = 8'h00;
    logic [7:0] hit, score, miss;
    logic       cout0;

    wam_judge #(.DB_CNT(DB), .LVL_PTS(LP)) dut (
        .clk(clk), .clr(clr), .sample_en(sample_en), .btn(btn),
        .holes(holes), .hit(hit), .score(score), .miss(miss), .cout0(cout0)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // background: random sampling strobe, tick counter, output monitors
    int ticks = 0;
    int rises2 = 0;
    int cout_rise = 0;
    int cout_hi = 0;

    initial forever begin
        @(negedge clk);
        sample_en = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(posedge clk);
        if (sample_en) ticks++;
    end

    initial begin
        logic p2, pc;
        p2 = 1'b0;
        pc = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hit[2] && !p2) rises2++;
            if (cout0) cout_hi++;
            if (cout0 && !pc) cout_rise++;
            p2 = hit[2];
            pc = cout0;
        end
    end

    // reference model
    int         m_score, m_miss, m_lvl, m_pulses, m_hits;
    logic [7:0] m_hit;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    task automatic model_svc(input int b);
        if (holes[b] && !m_hit[b]) begin
            m_hit[b] = 1'b1;
            m_hits++;
            if (m_score < 99) m_score++;
            m_lvl++;
            if (m_lvl == LP) begin
                m_lvl = 0;
                m_pulses++;
            end
        end else if (!holes[b]) begin
            if (m_miss < 99) m_miss++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, 32'(score), 32'(to_bcd(m_score)));
        chk({tag, ".miss"},  32'(miss),  32'(to_bcd(m_miss)));
        chk({tag, ".hit"},   32'(hit),   32'(m_hit));
        chk({tag, ".cout"},  32'(cout_rise), 32'(m_pulses));
    endtask

    task automatic wait_ticks(input int n);
        int t0;
        t0 = ticks;
        while (ticks - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_holes(input logic [7:0] h);
        holes = h;
        clks(2);
        m_hit = m_hit & h;
    endtask

    // clean press and release of every bit in m, serviced in index order
    task automatic press(input logic [7:0] m);
        btn = btn | m;
        wait_ticks(DB + 3);
        clks(12);
        for (int b = 0; b < 8; b++)
            if (m[b]) model_svc(b);
        btn = btn & ~m;
        wait_ticks(DB + 3);
        clks(2);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk({tag, ".rst_hit"},   32'(hit),   32'h0);
        chk({tag, ".rst_score"}, 32'(score), 32'h0);
        chk({tag, ".rst_miss"},  32'(miss),  32'h0);
        chk({tag, ".rst_cout"},  32'(cout0), 32'h0);
        clks(2);
        clr = 1'b0;
        m_score = 0;
        m_miss  = 0;
        m_lvl   = 0;
        m_hits  = 0;
        m_hit   = 8'h00;
    endtask

    initial begin
        int c[8];
        int c0, it, b;
        m_pulses = 0;

        do_reset("init");

        // T1 bounce on bit 2
        set_holes(8'h04);
        c0 = rises2;
        for (int j = 0; j < 13; j++) begin
            btn[2] = ~btn[2];
            wait_ticks(3);
        end
        btn[2] = 1'b1;
        wait_ticks(20);
        clks(12);
        model_svc(2);
        chk("t1.rises", 32'(rises2 - c0), 32'd1);
        check_all("t1");
        btn[2] = 1'b0;
        wait_ticks(DB + 3);
        clks(2);

        // T2 handshake on bit 5
        do_reset("t2");
        set_holes(8'h20);
        press(8'h20);
        check_all("t2.first");
        press(8'h20);
        check_all("t2.second");
        @(posedge clk);
        #1 holes[5] = 1'b0;
        #1 chk("t2.hold", 32'(hit[5]), 32'd1);
        clks(1);
        chk("t2.drop", 32'(hit[5]), 32'd0);
        m_hit[5] = 1'b0;

        // T3 misses
        do_reset("t3");
        set_holes(8'h00);
        press(8'h01);
        press(8'h08);
        press(8'h80);
        check_all("t3");

        // T4 arbitration: bits 1,4,6 stabilise together
        do_reset("t4");
        set_holes(8'hFF);
        for (int i = 0; i < 8; i++) c[i] = -1;
        btn = 8'h52;
        for (int cyc = 0; cyc < DB * 4 + 40; cyc++) begin
            clks(1);
            for (int i = 0; i < 8; i++)
                if (hit[i] && c[i] < 0) c[i] = cyc;
        end
        chk("t4.seen1", 32'(c[1] >= 0), 32'd1);
        chk("t4.gap14", 32'(c[4] - c[1]), 32'd1);
        chk("t4.gap46", 32'(c[6] - c[4]), 32'd1);
        model_svc(1);
        model_svc(4);
        model_svc(6);
        btn = 8'h00;
        wait_ticks(DB + 3);
        clks(2);
        check_all("t4");

        // T5 level pulses and saturation
        do_reset("t5");
        c0 = cout_rise;
        for (int i = 0; i < 10; i++) begin
            set_holes(8'h00);
            set_holes(8'hFF);
            press(8'(1 << (i % 8)));
            if (i == 8) chk("t5.nine", 32'(cout_rise - c0), 32'd0);
        end
        chk("t5.ten", 32'(cout_rise - c0), 32'd1);
        check_all("t5.ten");
        it = 0;
        while (m_hits < 105 && it < 400) begin
            set_holes(8'h00);
            set_holes(8'($urandom | $urandom));
            b = $urandom_range(0, 7);
            press(8'(1 << b));
            if (it % 25 == 0) check_all("t5.rand");
            it++;
        end
        chk("t5.hits", 32'(m_hits), 32'd105);
        chk("t5.score99", 32'(score), 32'h99);
        chk("t5.pulses", 32'(cout_rise - c0), 32'd10);
        check_all("t5.end");

        // T6 reset with presses in flight and hit[4] held
        do_reset("t6a");
        set_holes(8'h10);
        press(8'h10);
        check_all("t6.pre");
        btn = 8'h12;
        wait_ticks(DB);
        clks($urandom_range(0, 6));
        #1 clr = 1'b1;
        #1;
        chk("t6.hit0",   32'(hit),   32'h0);
        chk("t6.score0", 32'(score), 32'h0);
        chk("t6.miss0",  32'(miss),  32'h0);
        chk("t6.cout0",  32'(cout0), 32'h0);
        clks(2);
        clr = 1'b0;
        m_score = 0;
        m_miss  = 0;
        m_lvl   = 0;
        m_hit   = 8'h00;
        clks(4);
        check_all("t6.quiet");
        wait_ticks(DB + 3);
        clks(12);
        model_svc(1);
        model_svc(4);
        check_all("t6.held");
        btn = 8'h00;
        wait_ticks(DB + 3);
        clks(2);

        chk("cout.width", 32'(cout_hi), 32'(cout_rise));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
